// File: rtl/rtmc_spi_cmd.sv
// SPI command engine: turns the op/address/data byte stream of one frame into a
// single register bus read or write and produces the per-byte response stream.
module rtmc_spi_cmd #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 16,
   parameter int MAX_POLL = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_byte,
   output logic [7:0]        tx_byte,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic              bus_wr,
   output logic              bus_rd,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_ack,
   input  logic              bus_err,
   output logic              busy
);

   localparam logic [7:0] OP_NOP       = 8'h00;
   localparam logic [7:0] OP_RD        = 8'h01;
   localparam logic [7:0] OP_WR        = 8'h02;
   localparam logic [7:0] RES_BUSY     = 8'h00;
   localparam logic [7:0] RES_ACK      = 8'h01;
   localparam logic [7:0] RES_ACK_DATA = 8'h02;
   localparam logic [7:0] RES_ERROR    = 8'hFF;
   localparam logic [7:0] MAX_POLL_C   = 8'(MAX_POLL);

   typedef enum logic [3:0] {
      ST_IDLE, ST_ADDR, ST_WDH, ST_WDL, ST_WAIT, ST_RDH, ST_RDL, ST_DONE, ST_ERR
   } state_t;

   state_t            state_r, state_nxt_s;
   logic [7:0]        tx_nxt_s;
   logic [7:0]        poll_cnt_r, poll_nxt_s;
   logic              op_rd_r, op_rd_nxt_s;
   logic              addr_ld_s, wdh_ld_s, wdl_ld_s, req_set_s;
   logic              req_pending_r, req_rd_r;
   logic              own_r;
   logic              done_r, done_err_r;
   logic [DATA_W-1:0] rdata_r;
   logic              issue_s, cmpl_s, cmpl_err_s;

   // own_r marks an in-flight transaction that belongs to the current frame;
   // acks for aborted frames only release busy.
   assign cmpl_s     = done_r | (bus_ack & own_r);
   assign cmpl_err_s = done_r ? done_err_r : bus_err;
   assign issue_s    = req_pending_r & ~frame_start & ~busy & ~bus_wr & ~bus_rd;

   // FSM state, response byte and poll counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         tx_byte    <= 8'h00;
         poll_cnt_r <= 8'd0;
         op_rd_r    <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         tx_byte    <= tx_nxt_s;
         poll_cnt_r <= poll_nxt_s;
         op_rd_r    <= op_rd_nxt_s;
      end
   end

   // next-state, next response byte and datapath load controls
   always_comb begin
      state_nxt_s = state_r;
      tx_nxt_s    = tx_byte;
      poll_nxt_s  = poll_cnt_r;
      op_rd_nxt_s = op_rd_r;
      addr_ld_s   = 1'b0;
      wdh_ld_s    = 1'b0;
      wdl_ld_s    = 1'b0;
      req_set_s   = 1'b0;
      if (frame_start) begin
         state_nxt_s = ST_IDLE;
         tx_nxt_s    = RES_BUSY;
         poll_nxt_s  = 8'd0;
      end else if (rx_valid) begin
         case (state_r)
            ST_IDLE: begin
               case (rx_byte)
                  OP_RD: begin
                     op_rd_nxt_s = 1'b1;
                     tx_nxt_s    = RES_BUSY;
                     state_nxt_s = ST_ADDR;
                  end
                  OP_WR: begin
                     op_rd_nxt_s = 1'b0;
                     tx_nxt_s    = RES_BUSY;
                     state_nxt_s = ST_ADDR;
                  end
                  OP_NOP: begin
                     tx_nxt_s    = RES_ACK;
                     state_nxt_s = ST_DONE;
                  end
                  default: begin
                     tx_nxt_s    = RES_ERROR;
                     state_nxt_s = ST_ERR;
                  end
               endcase
            end
            ST_ADDR: begin
               addr_ld_s = 1'b1;
               tx_nxt_s  = RES_BUSY;
               if (op_rd_r) begin
                  req_set_s   = 1'b1;
                  state_nxt_s = ST_WAIT;
               end else begin
                  state_nxt_s = ST_WDH;
               end
            end
            ST_WDH: begin
               wdh_ld_s    = 1'b1;
               tx_nxt_s    = RES_BUSY;
               state_nxt_s = ST_WDL;
            end
            ST_WDL: begin
               wdl_ld_s    = 1'b1;
               req_set_s   = 1'b1;
               tx_nxt_s    = RES_BUSY;
               state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
               if (cmpl_s) begin
                  if (cmpl_err_s) begin
                     tx_nxt_s    = RES_ERROR;
                     state_nxt_s = ST_ERR;
                  end else if (op_rd_r) begin
                     tx_nxt_s    = RES_ACK_DATA;
                     state_nxt_s = ST_RDH;
                  end else begin
                     tx_nxt_s    = RES_ACK;
                     state_nxt_s = ST_DONE;
                  end
               end else if (poll_cnt_r < MAX_POLL_C) begin
                  tx_nxt_s   = RES_BUSY;
                  poll_nxt_s = poll_cnt_r + 8'd1;
               end else begin
                  tx_nxt_s    = RES_ERROR;
                  state_nxt_s = ST_ERR;
               end
            end
            ST_RDH: begin
               tx_nxt_s    = rdata_r[DATA_W-1 -: 8];
               state_nxt_s = ST_RDL;
            end
            ST_RDL: begin
               tx_nxt_s    = rdata_r[7:0];
               state_nxt_s = ST_DONE;
            end
            ST_DONE: begin
               tx_nxt_s = RES_BUSY;
            end
            ST_ERR: begin
               tx_nxt_s = RES_ERROR;
            end
            default: begin
               tx_nxt_s    = RES_ERROR;
               state_nxt_s = ST_ERR;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // bus address/data latches, strobe issue, busy and completion capture
   always_ff @(posedge clk) begin
      if (rst) begin
         bus_addr      <= '0;
         bus_wdata     <= '0;
         bus_wr        <= 1'b0;
         bus_rd        <= 1'b0;
         busy          <= 1'b0;
         req_pending_r <= 1'b0;
         req_rd_r      <= 1'b0;
         own_r         <= 1'b0;
         done_r        <= 1'b0;
         done_err_r    <= 1'b0;
         rdata_r       <= '0;
      end else begin
         if (addr_ld_s) bus_addr <= ADDR_W'(rx_byte);
         if (wdh_ld_s)  bus_wdata[DATA_W-1 -: 8] <= rx_byte;
         if (wdl_ld_s)  bus_wdata[7:0] <= rx_byte;
         bus_wr <= issue_s & ~req_rd_r;
         bus_rd <= issue_s & req_rd_r;

         if (frame_start)    req_pending_r <= 1'b0;
         else if (req_set_s) req_pending_r <= 1'b1;
         else if (issue_s)   req_pending_r <= 1'b0;
         if (req_set_s)      req_rd_r      <= op_rd_r;

         if (bus_ack)               busy <= 1'b0;
         else if (bus_wr || bus_rd) busy <= 1'b1;

         if (frame_start)  own_r <= 1'b0;
         else if (issue_s) own_r <= 1'b1;
         else if (bus_ack) own_r <= 1'b0;

         if (frame_start || req_set_s) begin
            done_r     <= 1'b0;
            done_err_r <= 1'b0;
         end else if (bus_ack && own_r) begin
            done_r     <= 1'b1;
            done_err_r <= bus_err;
         end
         if (bus_ack && own_r && !frame_start) rdata_r <= bus_rdata;
      end
   end

endmodule
